// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU execute block and its control decoder.
package alu_pkg;

    // ALU control codes carried from decode into the datapath
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_SRL     = 4'b0100;
    localparam logic [3:0] ALU_SLL     = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SRA     = 4'b0111;
    localparam logic [3:0] ALU_SLT     = 4'b1000;
    localparam logic [3:0] ALU_SLTU    = 4'b1001;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    // aluOp encodings produced by the main control stage
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // Execute FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } aluState_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps aluOp plus {funct7[5], funct3} onto an ALU control code and flags
// encodings that have no legal RV32I meaning. Purely combinational so the
// branch unit can share it.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [3:0] f3f7,
    output logic [3:0] aluCtrl,
    output logic       illegal
);

    logic       f7;
    logic [2:0] f3;

    assign f7 = f3f7[3];
    assign f3 = f3f7[2:0];

    // Table lookup on funct3; funct7[5] only selects sub/sra, anything else with it set is illegal
    always_comb begin
        aluCtrl = ALU_ILLEGAL;
        illegal = 1'b0;
        case (aluOp)
            ALUOP_ADD: aluCtrl = ALU_ADD;
            ALUOP_SUB: aluCtrl = ALU_SUB;
            default: begin
                case (f3)
                    3'b000: begin
                        if (aluOp == ALUOP_RTYPE && f7) aluCtrl = ALU_SUB;
                        else                            aluCtrl = ALU_ADD;
                    end
                    3'b001: begin aluCtrl = ALU_SLL;  illegal = f7; end
                    3'b010: begin aluCtrl = ALU_SLT;  illegal = f7; end
                    3'b011: begin aluCtrl = ALU_SLTU; illegal = f7; end
                    3'b100: begin aluCtrl = ALU_XOR;  illegal = f7; end
                    3'b101: aluCtrl = f7 ? ALU_SRA : ALU_SRL;
                    3'b110: begin aluCtrl = ALU_OR;   illegal = f7; end
                    default: begin aluCtrl = ALU_AND; illegal = f7; end
                endcase
                if (illegal) aluCtrl = ALU_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/alu_iter_unit.sv
// ALU execute block with valid/ready handshake. Non-shift ops finish in one
// cycle; shifts walk the working register SHIFT_STEP bits per cycle.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int SHIFT_STEP = 1,
    localparam int SHAMT_W    = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      aluOp,
    input  logic [3:0]      f3f7,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic [3:0]      aluCtrl
);

    localparam logic [SHAMT_W:0] STEP_EXT = (SHAMT_W+1)'(SHIFT_STEP);

    aluState_t        state, nextState;
    logic [3:0]       decCtrl, ctrlReg;
    logic             decIllegal, illegalReg, zeroReg;
    logic [XLEN-1:0]  quickResult, workReg, resultReg, shifted;
    logic [SHAMT_W-1:0] shamt, remaining, stepAmt;
    logic             decIsShift, startShift, shiftLast;

    alu_ctrl_decode uDecode (
        .aluOp   (aluOp),
        .f3f7    (f3f7),
        .aluCtrl (decCtrl),
        .illegal (decIllegal)
    );

    assign shamt      = opB[SHAMT_W-1:0];
    assign decIsShift = (decCtrl == ALU_SLL) || (decCtrl == ALU_SRL) || (decCtrl == ALU_SRA);
    assign startShift = decIsShift && (shamt != '0);
    assign stepAmt    = ({1'b0, remaining} < STEP_EXT) ? remaining : STEP_EXT[SHAMT_W-1:0];
    assign shiftLast  = (remaining == stepAmt);

    // Single-cycle result for everything except a non-zero shift; illegal ops give zero
    always_comb begin
        quickResult = '0;
        case (decCtrl)
            ALU_AND:  quickResult = opA & opB;
            ALU_OR:   quickResult = opA | opB;
            ALU_ADD:  quickResult = opA + opB;
            ALU_XOR:  quickResult = opA ^ opB;
            ALU_SUB:  quickResult = opA - opB;
            ALU_SLT:  quickResult = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
            ALU_SLTU: quickResult = {{(XLEN-1){1'b0}}, (opA < opB)};
            ALU_SLL, ALU_SRL, ALU_SRA: quickResult = opA;
            default:  quickResult = '0;
        endcase
    end

    // One shifter step; arithmetic shift keeps replicating the original sign bit
    always_comb begin
        shifted = workReg;
        case (ctrlReg)
            ALU_SLL: shifted = workReg << stepAmt;
            ALU_SRA: shifted = $signed(workReg) >>> stepAmt;
            default: shifted = workReg >> stepAmt;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    // FSM next-state logic
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:  if (in_valid) nextState = startShift ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (shiftLast) nextState = ST_DONE;
            ST_DONE:  if (out_ready) nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake flags follow the state directly
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Datapath: latch the request on acceptance, iterate the shifter, hold results through DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrlReg    <= ALU_AND;
            illegalReg <= 1'b0;
            zeroReg    <= 1'b0;
            resultReg  <= '0;
            workReg    <= '0;
            remaining  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ctrlReg    <= decCtrl;
                        illegalReg <= decIllegal;
                        if (startShift) begin
                            workReg   <= opA;
                            remaining <= shamt;
                        end else begin
                            resultReg <= quickResult;
                            zeroReg   <= (quickResult == '0);
                        end
                    end
                end
                ST_SHIFT: begin
                    workReg   <= shifted;
                    remaining <= remaining - stepAmt;
                    if (shiftLast) begin
                        resultReg <= shifted;
                        zeroReg   <= (shifted == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result  = resultReg;
    assign zero    = zeroReg;
    assign illegal = illegalReg;
    assign aluCtrl = ctrlReg;

endmodule

// File: tb/tb_alu_iter_unit.sv
// Testbench for alu_iter_unit: two instances (SHIFT_STEP 1 and 4) sharing
// the request bus, checked against a spec-level reference model.
module tb_alu_iter_unit;

    localparam logic [3:0] C_AND = 4'h0, C_OR = 4'h1, C_ADD = 4'h2, C_XOR = 4'h3;
    localparam logic [3:0] C_SRL = 4'h4, C_SLL = 4'h5, C_SUB = 4'h6, C_SRA = 4'h7;
    localparam logic [3:0] C_SLT = 4'h8, C_SLTU = 4'h9, C_ILL = 4'hF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;
    logic [1:0]  aluOp = 2'b00;
    logic [3:0]  f3f7 = 4'h0;
    logic [31:0] opA = '0, opB = '0;

    logic        inValid1, inValid4, outReady1, outReady4;
    logic        inReady1, inReady4, outValid1, outValid4;
    logic        zero1, zero4, illegal1, illegal4;
    logic [31:0] result1, result4;
    logic [3:0]  aluCtrl1, aluCtrl4;

    logic        inReadyV, outValidV, zeroV, illegalV;
    logic [31:0] resultV;
    logic [3:0]  aluCtrlV;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    assign inValid1  = inValid  & ~sel;
    assign inValid4  = inValid  &  sel;
    assign outReady1 = outReady & ~sel;
    assign outReady4 = outReady &  sel;

    assign inReadyV  = sel ? inReady4  : inReady1;
    assign outValidV = sel ? outValid4 : outValid1;
    assign resultV   = sel ? result4   : result1;
    assign zeroV     = sel ? zero4     : zero1;
    assign illegalV  = sel ? illegal4  : illegal1;
    assign aluCtrlV  = sel ? aluCtrl4  : aluCtrl1;

    alu_iter_unit #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(inValid1), .in_ready(inReady1),
        .aluOp(aluOp), .f3f7(f3f7), .opA(opA), .opB(opB),
        .out_valid(outValid1), .out_ready(outReady1), .result(result1),
        .zero(zero1), .illegal(illegal1), .aluCtrl(aluCtrl1)
    );

    alu_iter_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(inValid4), .in_ready(inReady4),
        .aluOp(aluOp), .f3f7(f3f7), .opA(opA), .opB(opB),
        .out_valid(outValid4), .out_ready(outReady4), .result(result4),
        .zero(zero4), .illegal(illegal4), .aluCtrl(aluCtrl4)
    );

    // Reference model straight from the decode table and RV32I semantics
    function automatic void refModel(input logic [1:0] op, input logic [3:0] ff,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [3:0] ctrl, output logic ill,
                                     output logic [31:0] res);
        logic [3:0] baseTable [8];
        logic [4:0] sh;
        baseTable = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};
        sh  = b[4:0];
        ill = 1'b0;
        if (op == 2'b00)      ctrl = C_ADD;
        else if (op == 2'b01) ctrl = C_SUB;
        else begin
            ctrl = baseTable[ff[2:0]];
            if (ff[3]) begin
                if (ff[2:0] == 3'd5)                     ctrl = C_SRA;
                else if (ff[2:0] == 3'd0 && op == 2'b10) ctrl = C_SUB;
                else if (ff[2:0] != 3'd0)                ill  = 1'b1;
            end
        end
        if (ill) ctrl = C_ILL;
        case (ctrl)
            C_AND:  res = a & b;
            C_OR:   res = a | b;
            C_ADD:  res = a + b;
            C_XOR:  res = a ^ b;
            C_SUB:  res = a - b;
            C_SLL:  res = a << sh;
            C_SRL:  res = a >> sh;
            C_SRA:  res = 32'($signed(a) >>> sh);
            C_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request to the selected instance, wait for its result, check it and drain it
    task automatic applyStimulus(input logic s, input logic [1:0] op, input logic [3:0] ff,
                                 input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [3:0]  expCtrl;
        logic        expIll;
        logic [31:0] expRes;
        int          step, expLat, lat, waitCnt;
        refModel(op, ff, a, b, expCtrl, expIll, expRes);
        step   = s ? 4 : 1;
        expLat = 1;
        if ((expCtrl == C_SLL || expCtrl == C_SRL || expCtrl == C_SRA) && b[4:0] != 5'd0)
            expLat = 1 + (int'(b[4:0]) + step - 1) / step;
        @(negedge clk);
        sel = s; aluOp = op; f3f7 = ff; opA = a; opB = b; inValid = 1'b1;
        waitCnt = 0;
        while (!inReadyV && waitCnt < 100) begin @(negedge clk); waitCnt++; end
        checkOutput({tag, " in_ready"}, {31'd0, inReadyV}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        lat = 1;
        while (!outValidV && lat < 100) begin @(negedge clk); lat++; end
        checkOutput({tag, " latency"}, lat, expLat);
        checkOutput({tag, " result"}, resultV, expRes);
        checkOutput({tag, " zero"}, {31'd0, zeroV}, {31'd0, expRes == 32'd0});
        checkOutput({tag, " illegal"}, {31'd0, illegalV}, {31'd0, expIll});
        checkOutput({tag, " aluCtrl"}, {28'd0, aluCtrlV}, {28'd0, expCtrl});
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput({tag, " back to idle"}, {30'd0, inReadyV, outValidV}, 32'd2);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst in_ready", {31'd0, inReady1}, 32'd1);
        checkOutput("rst out_valid", {31'd0, outValid1}, 32'd0);
        checkOutput("rst result", result1, 32'd0);
        checkOutput("rst zero/illegal", {30'd0, zero1, illegal1}, 32'd0);
        checkOutput("rst aluCtrl", {28'd0, aluCtrl1}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post-rst out_valid", {31'd0, outValid4}, 32'd0);

        // Directed cases
        applyStimulus(1'b0, 2'b10, 4'b1000, 32'd5, 32'd7, "rtype sub");
        applyStimulus(1'b0, 2'b01, 4'b0000, 32'd9, 32'd9, "sub zero");
        applyStimulus(1'b0, 2'b10, 4'b1101, 32'h8000_0000, 32'd4, "sra step1");
        applyStimulus(1'b1, 2'b10, 4'b1101, 32'h8000_0000, 32'd4, "sra step4");
        applyStimulus(1'b0, 2'b10, 4'b1101, 32'h8000_0000, 32'd0, "sra shamt0");
        applyStimulus(1'b0, 2'b10, 4'b1001, 32'd12, 32'd3, "rtype illegal");
        applyStimulus(1'b0, 2'b11, 4'b1001, 32'd12, 32'd3, "itype illegal");
        applyStimulus(1'b0, 2'b11, 4'b1000, 32'd12, 32'd3, "itype add f7");
        applyStimulus(1'b0, 2'b10, 4'b0010, 32'hFFFF_FFFF, 32'd1, "slt");
        applyStimulus(1'b0, 2'b10, 4'b0011, 32'hFFFF_FFFF, 32'd1, "sltu");
        applyStimulus(1'b1, 2'b11, 4'b0001, 32'h0000_00F1, 32'd31, "sll 31 step4");
        applyStimulus(1'b0, 2'b11, 4'b0101, 32'hF000_0000, 32'd31, "srl 31 step1");

        // Reset asserted mid-shift aborts the operation immediately
        @(negedge clk);
        sel = 1'b0; aluOp = 2'b10; f3f7 = 4'b0001; opA = 32'd1; opB = 32'd20; inValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid-shift rst out_valid", {31'd0, outValid1}, 32'd0);
        checkOutput("mid-shift rst in_ready", {31'd0, inReady1}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 2'b00, 4'b0000, 32'd3, 32'd4, "add after rst");

        // Backpressure: result held while out_ready is low, new request waits
        @(negedge clk);
        sel = 1'b0; aluOp = 2'b00; f3f7 = 4'h0; opA = 32'd10; opB = 32'd20; inValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aluOp = 2'b10; f3f7 = 4'b0100; opA = 32'h0000_FF00; opB = 32'h0000_0FF0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stall%0d out_valid", i), {31'd0, outValid1}, 32'd1);
            checkOutput($sformatf("stall%0d in_ready", i), {31'd0, inReady1}, 32'd0);
            checkOutput($sformatf("stall%0d result", i), result1, 32'd30);
            checkOutput($sformatf("stall%0d aluCtrl", i), {28'd0, aluCtrl1}, {28'd0, C_ADD});
            @(negedge clk);
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("release idle", {30'd0, inReady1, outValid1}, 32'd2);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("held req out_valid", {31'd0, outValid1}, 32'd1);
        checkOutput("held req result", result1, 32'h0000_F0F0);
        checkOutput("held req aluCtrl", {28'd0, aluCtrl1}, {28'd0, C_XOR});
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;

        // Randomized operations on both instances
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (n % 4 == 0) rb = rb & 32'h1F;
            if (n % 7 == 0) ra = rb;
            applyStimulus(1'(($urandom >> 3) & 1), 2'($urandom), 4'($urandom), ra, rb,
                          $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
